div_iter: RTL and testbench

//  Iterative unsigned divider: the sequential inverse of the combinational multiplier primitive.

---
 rtl/div_iter.sv | 146 ++++++++++++++
 tb/tb_div_iter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : Iterative unsigned divider, restoring radix-2, one quotient
//               bit per clock. Valid/ready handshake on input and output.
//               Optional macro DIV_ITER_DIV0_FLAG_EN adds the div_zero output,
//               which flags a result produced from a zero divisor.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
`ifdef DIV_ITER_DIV0_FLAG_EN
   ,
   output logic             div_zero
`endif
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH:0]     rem_q, rem_d;     // partial remainder R
   logic [WIDTH-1:0]   quo_q, quo_d;     // dividend shifting out / quotient shifting in
   logic [WIDTH-1:0]   dvs_q, dvs_d;     // divisor latched on accept
   logic [WIDTH-1:0]   qout_q, qout_d;   // published quotient, survives next accept
   logic [WIDTH-1:0]   rout_q, rout_d;   // published remainder, survives next accept

   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_trial;
   logic [WIDTH:0]     w_iter_rem;
   logic [WIDTH-1:0]   w_iter_quo;

   // One restoring step: shift in the next dividend bit, try the subtraction,
   // keep it only if the result is non-negative.
   always_comb begin
      w_shift    = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      w_trial    = w_shift - {1'b0, dvs_q};
      w_iter_rem = w_trial[WIDTH] ? w_shift : w_trial;
      w_iter_quo = {quo_q[WIDTH-2:0], ~w_trial[WIDTH]};
   end

   // Next-state and handshake decode.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      qout_d    = qout_q;
      rout_d    = rout_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               quo_d   = dividend;
               rem_d   = '0;
               dvs_d   = divisor;
               cnt_d   = CNT_LAST;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            rem_d = w_iter_rem;
            quo_d = w_iter_quo;
            if (cnt_q == '0) begin
               qout_d  = w_iter_quo;
               rout_d  = w_iter_rem[WIDTH-1:0];
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            // Returning to IDLE takes this edge; a pending in_valid waits one more.
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         qout_q  <= '0;
         rout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         qout_q  <= qout_d;
         rout_q  <= rout_d;
      end
   end

   assign quotient  = qout_q;
   assign remainder = rout_q;

`ifdef DIV_ITER_DIV0_FLAG_EN
   logic dz_q;

   // Zero-divisor flag captured at accept; stays put through DONE and beyond.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dz_q <= 1'b0;
      end else if (state_q == S_IDLE && in_valid) begin
         dz_q <= (divisor == '0);
      end
   end

   assign div_zero = dz_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_iter
// Description : Self-checking bench for div_iter, one WIDTH=8 and one
//               WIDTH=32 instance, directed plus random operations compared
//               against plain a/b, a%b arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        iv8, or8, iv32, or32;
   logic [7:0]  a8, b8;
   logic [31:0] a32, b32;
   logic        ir8, ov8, ir32, ov32;
   logic [7:0]  q8, r8;
   logic [31:0] q32, r32;
`ifdef DIV_ITER_DIV0_FLAG_EN
   logic        dz8, dz32;
`endif

   int checks   = 0;
   int failures = 0;

   div_iter #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (iv8),
      .in_ready  (ir8),
      .dividend  (a8),
      .divisor   (b8),
      .out_valid (ov8),
      .out_ready (or8),
      .quotient  (q8),
      .remainder (r8)
`ifdef DIV_ITER_DIV0_FLAG_EN
      ,
      .div_zero  (dz8)
`endif
   );

   div_iter #(.WIDTH(32)) u_dut32 (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (iv32),
      .in_ready  (ir32),
      .dividend  (a32),
      .divisor   (b32),
      .out_valid (ov32),
      .out_ready (or32),
      .quotient  (q32),
      .remainder (r32)
`ifdef DIV_ITER_DIV0_FLAG_EN
      ,
      .div_zero  (dz32)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: ordinary integer division; zero divisor gives all ones / dividend.
   function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b, input bit w32);
      if (b == 0) return w32 ? 32'hFFFF_FFFF : 32'h0000_00FF;
      return a / b;
   endfunction

   function automatic logic [31:0] ref_r(input logic [31:0] a, input logic [31:0] b);
      if (b == 0) return a;
      return a % b;
   endfunction

   function automatic logic rdy(input bit w32);  return w32 ? ir32 : ir8; endfunction
   function automatic logic vld(input bit w32);  return w32 ? ov32 : ov8; endfunction
   function automatic logic [31:0] quo(input bit w32); return w32 ? q32 : {24'd0, q8}; endfunction
   function automatic logic [31:0] rem(input bit w32); return w32 ? r32 : {24'd0, r8}; endfunction

   task automatic set_in(input bit w32, input logic v, input logic [31:0] a, input logic [31:0] b);
      if (w32) begin
         iv32 = v; a32 = a; b32 = b;
      end else begin
         iv8 = v; a8 = a[7:0]; b8 = b[7:0];
      end
   endtask

   task automatic set_ordy(input bit w32, input logic v);
      if (w32) or32 = v; else or8 = v;
   endtask

   // Present operands and return just after the accepting edge.
   task automatic accept(input bit w32, input logic [31:0] a, input logic [31:0] b);
      int n = 0;
      set_in(w32, 1'b1, a, b);
      while (!rdy(w32) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("accept_timeout", 64'(n < 200), 64'd1);
      @(posedge clk); #1;
      // Garbage on the operand ports while busy must be ignored.
      set_in(w32, 1'b0, $urandom, $urandom);
   endtask

   task automatic wait_result(input bit w32, input string tag);
      int lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!vld(w32) && lat < 100);
      chk({tag, "_latency"}, 64'(lat), w32 ? 64'd32 : 64'd8);
   endtask

   task automatic check_res(input bit w32, input logic [31:0] a, input logic [31:0] b, input string tag);
      chk({tag, "_quotient"},  64'(quo(w32)), 64'(ref_q(a, b, w32)));
      chk({tag, "_remainder"}, 64'(rem(w32)), 64'(ref_r(a, b)));
`ifdef DIV_ITER_DIV0_FLAG_EN
      chk({tag, "_div_zero"}, w32 ? 64'(dz32) : 64'(dz8), 64'(b == 0));
`endif
   endtask

   task automatic release_out(input bit w32, input string tag);
      set_ordy(w32, 1'b1);
      @(posedge clk); #1;
      set_ordy(w32, 1'b0);
      chk({tag, "_valid_drop"}, 64'(vld(w32)), 64'd0);
      chk({tag, "_ready_back"}, 64'(rdy(w32)), 64'd1);
   endtask

   task automatic full_op(input bit w32, input logic [31:0] a, input logic [31:0] b, input string tag);
      accept(w32, a, b);
      wait_result(w32, tag);
      check_res(w32, a, b, tag);
      release_out(w32, tag);
      chk({tag, "_held_after"}, 64'(quo(w32)), 64'(ref_q(a, b, w32)));
   endtask

   initial begin
      logic [31:0] ra, rb;
      reset_n = 1'b0;
      iv8 = 0; or8 = 0; a8 = 0; b8 = 0;
      iv32 = 0; or32 = 0; a32 = 0; b32 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready8",   64'(ir8), 64'd1);
      chk("rst_out_valid8",  64'(ov8), 64'd0);
      chk("rst_quotient8",   64'(q8),  64'd0);
      chk("rst_remainder8",  64'(r8),  64'd0);
      chk("rst_in_ready32",  64'(ir32), 64'd1);
      chk("rst_out_valid32", 64'(ov32), 64'd0);
`ifdef DIV_ITER_DIV0_FLAG_EN
      chk("rst_div_zero8", 64'(dz8), 64'd0);
`endif
      reset_n = 1'b1;

      // Basic divide with immediate consumption.
      full_op(1'b0, 32'd100, 32'd7, "d100_7");

      // 255/1 then 5/9 requested while the first result is still in DONE.
      accept(1'b0, 32'd255, 32'd1);
      wait_result(1'b0, "d255_1");
      check_res(1'b0, 32'd255, 32'd1, "d255_1");
      set_in(1'b0, 1'b1, 32'd5, 32'd9);
      or8 = 1'b1;
      @(posedge clk); #1;
      or8 = 1'b0;
      chk("b2b_no_accept_in_done", 64'(ir8), 64'd1);
      chk("b2b_valid_drop",        64'(ov8), 64'd0);
      @(posedge clk); #1;
      chk("b2b_accept_from_idle",  64'(ir8), 64'd0);
      set_in(1'b0, 1'b0, $urandom, $urandom);
      wait_result(1'b0, "d5_9");
      check_res(1'b0, 32'd5, 32'd9, "d5_9");
      release_out(1'b0, "d5_9");

      // Divide by zero.
      full_op(1'b0, 32'd37, 32'd0, "d37_0");

      // Backpressure with a competing request held on the input.
      accept(1'b0, 32'd200, 32'd3);
      wait_result(1'b0, "d200_3");
      set_in(1'b0, 1'b1, 32'd9, 32'd9);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_out_valid", 64'(ov8), 64'd1);
         chk("bp_in_ready",  64'(ir8), 64'd0);
         chk("bp_quotient",  64'(q8),  64'd66);
         chk("bp_remainder", 64'(r8),  64'd2);
      end
      set_in(1'b0, 1'b0, 32'd0, 32'd0);
      release_out(1'b0, "d200_3");
      check_res(1'b0, 32'd200, 32'd3, "d200_3_after");

      // Asynchronous reset in the middle of an operation.
      accept(1'b0, 32'd50, 32'd5);
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_in_ready",  64'(ir8), 64'd1);
      chk("midrst_out_valid", 64'(ov8), 64'd0);
      chk("midrst_quotient",  64'(q8),  64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      full_op(1'b0, 32'd50, 32'd5, "d50_5");

      // Random 8-bit pairs, including the occasional zero divisor.
      for (int i = 0; i < 6; i++) begin
         ra = $urandom_range(0, 255);
         rb = (i == 3) ? 32'd0 : 32'($urandom_range(0, 255));
         full_op(1'b0, ra, rb, "rand8");
      end

      // 32-bit directed cases.
      full_op(1'b1, 32'hFFFF_FFFF, 32'h0001_0000, "w32_ffff");
      full_op(1'b1, 32'h1234_5678, 32'h0000_0000, "w32_div0");
      full_op(1'b1, 32'h0000_0000, 32'h0000_0013, "w32_zero_num");

      // Random 32-bit pairs over small and full-range divisors.
      for (int i = 0; i < 12; i++) begin
         ra = $urandom;
         rb = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
         full_op(1'b1, ra, rb, "rand32");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop in case the sequence itself wedges.
   initial begin
      #2_000_000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
